// File: rtl/sm83_irq_ctl_if.sv
// CPU-side memory-mapped bus used to reach the IF/IE registers.
// The CPU drives address, data and strobes; the controller returns registered read data.
interface sm83_irq_ctl_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADR_WIDTH = 16
);
    logic [ADR_WIDTH-1:0] adr;
    logic [WORD_SIZE-1:0] din;
    logic [WORD_SIZE-1:0] dout;
    logic                 dout_oe;
    logic                 rd;
    logic                 wr;

    modport master (
        output adr, din, rd, wr,
        input  dout, dout_oe
    );

    modport slave (
        input  adr, din, rd, wr,
        output dout, dout_oe
    );
endinterface

// File: rtl/sm83_irq_ctl.sv
// sm83 interrupt controller: IF/IE registers, request edge latching, irq/wake, bus slave.
// Define SM83_IRQ_SYNC_EN to pass src_req through a 2-flop synchronizer.
module sm83_irq_ctl #(
    parameter int                   WORD_SIZE = 8,
    parameter int                   ADR_WIDTH = 16,
    parameter int                   NUM_SRC   = 5,
    parameter logic [ADR_WIDTH-1:0] IF_ADR    = 16'hFF0F,
    parameter logic [ADR_WIDTH-1:0] IE_ADR    = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    sm83_irq_ctl_if.slave        bus,
    input  logic [NUM_SRC-1:0]   src_req,
    output logic [WORD_SIZE-1:0] irq,
    input  logic [WORD_SIZE-1:0] iack,
    output logic                 wake
);

    logic [NUM_SRC-1:0]   if_q;
    logic [NUM_SRC-1:0]   if_next;
    logic [WORD_SIZE-1:0] ie_q;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   prev;
    logic [NUM_SRC-1:0]   rise;
    logic [WORD_SIZE-1:0] if_rd;
    logic                 hit_if;
    logic                 hit_ie;
    logic                 unused_ok;

    assign unused_ok = ^iack;
    assign hit_if    = (bus.adr == IF_ADR);
    assign hit_ie    = (bus.adr == IE_ADR);

`ifdef SM83_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_req;
            sync2 <= sync1;
        end
    end

    assign req = sync2;
`else
    assign req = src_req;
`endif

    assign rise = req & ~prev;

    // Edge set is applied last so a new request survives a same-cycle ack or clear.
    always_comb begin
        if_next = if_q;
        if (bus.wr && hit_if)
            if_next = bus.din[NUM_SRC-1:0];
        if_next = if_next & ~iack[NUM_SRC-1:0];
        if_next = if_next | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
            if_q <= '0;
            ie_q <= '0;
        end else begin
            prev <= req;
            if_q <= if_next;
            if (bus.wr && hit_ie)
                ie_q <= bus.din;
        end
    end

    always_comb begin
        if_rd              = '1;
        if_rd[NUM_SRC-1:0] = if_q;
    end

    // Read data is sampled from pre-update registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dout    <= '0;
            bus.dout_oe <= 1'b0;
        end else begin
            bus.dout_oe <= 1'b0;
            if (bus.rd && hit_if) begin
                bus.dout    <= if_rd;
                bus.dout_oe <= 1'b1;
            end else if (bus.rd && hit_ie) begin
                bus.dout    <= ie_q;
                bus.dout_oe <= 1'b1;
            end
        end
    end

    always_comb begin
        irq              = '0;
        irq[NUM_SRC-1:0] = if_q & ie_q[NUM_SRC-1:0];
    end

    assign wake = |irq;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed self-checking bench for sm83_irq_ctl.
// Request latency expectation follows SM83_IRQ_SYNC_EN.
module tb_sm83_irq_ctl;

    logic       clk;
    logic       reset;
    logic [4:0] src_req;
    logic [7:0] irq;
    logic [7:0] iack;
    logic       wake;
    int         total;
    int         bad;
    int         lat;

`ifdef SM83_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    sm83_irq_ctl_if #(.WORD_SIZE(8), .ADR_WIDTH(16)) bus ();

    sm83_irq_ctl dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .src_req (src_req),
        .irq     (irq),
        .iack    (iack),
        .wake    (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        bus.adr = a;
        bus.din = d;
        bus.wr  = 1'b1;
        tick();
        bus.wr  = 1'b0;
    endtask

    task automatic rd_reg(input logic [15:0] a);
        bus.adr = a;
        bus.rd  = 1'b1;
        tick();
        bus.rd  = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        src_req = '0;
        iack    = '0;
        bus.adr = '0;
        bus.din = '0;
        bus.rd  = 1'b0;
        bus.wr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_irq", irq, 8'h00);
        chk("rst_wake", {7'd0, wake}, 8'h00);
        chk("rst_oe", {7'd0, bus.dout_oe}, 8'h00);
        chk("rst_dout", bus.dout, 8'h00);

        // 1: single request, read IF
        wr_reg(16'hFFFF, 8'h01);
        src_req = 5'h01;
        tick();
        src_req = 5'h00;
        chk("t1_irq", irq, 8'h01);
        chk("t1_wake", {7'd0, wake}, 8'h01);
        rd_reg(16'hFF0F);
        chk("t1_dout", bus.dout, 8'hE1);
        chk("t1_oe", {7'd0, bus.dout_oe}, 8'h01);
        tick();
        chk("t1_oe_drop", {7'd0, bus.dout_oe}, 8'h00);

        // 2: masked request
        iack = 8'h01;
        tick();
        iack = 8'h00;
        wr_reg(16'hFFFF, 8'h00);
        src_req = 5'h04;
        tick();
        chk("t2_irq", irq, 8'h00);
        chk("t2_wake", {7'd0, wake}, 8'h00);
        rd_reg(16'hFF0F);
        chk("t2_if", bus.dout, 8'hE4);
        wr_reg(16'hFFFF, 8'h04);
        chk("t2_irq_en", irq, 8'h04);
        src_req = 5'h00;

        // 3: acknowledge one at a time
        wr_reg(16'hFF0F, 8'h05);
        wr_reg(16'hFFFF, 8'h1F);
        chk("t3_irq", irq, 8'h05);
        iack = 8'h01;
        tick();
        chk("t3_ack0", irq, 8'h04);
        iack = 8'h04;
        tick();
        iack = 8'h00;
        chk("t3_ack2", irq, 8'h00);
        chk("t3_wake", {7'd0, wake}, 8'h00);

        // 4: edge beats ack and CPU clear
        wr_reg(16'hFF0F, 8'h02);
        iack    = 8'h02;
        src_req = 5'h02;
        tick();
        iack    = 8'h00;
        src_req = 5'h00;
        chk("t4_ack_race", irq, 8'h02);
        tick();
        src_req = 5'h08;
        wr_reg(16'hFF0F, 8'h00);
        src_req = 5'h00;
        chk("t4_wr_race", irq, 8'h08);

        // multi-bit ack and ack of non-pending bits
        wr_reg(16'hFF0F, 8'h1F);
        iack = 8'h13;
        tick();
        chk("multi_ack", irq, 8'h0C);
        tick();
        chk("nonpend_ack", irq, 8'h0C);
        iack = 8'h0C;
        tick();
        iack = 8'h00;

        // 5: held level gives one request
        src_req = 5'h10;
        tick();
        chk("t5_req", irq, 8'h10);
        iack = 8'h10;
        tick();
        iack = 8'h00;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_held", irq, 8'h00);
        src_req = 5'h00;
        wr_reg(16'hFFFF, 8'hA5);
        rd_reg(16'hFFFF);
        chk("t5_ie", bus.dout, 8'hA5);
        rd_reg(16'hFF00);
        chk("t5_oe_other", {7'd0, bus.dout_oe}, 8'h00);
        chk("t5_dout_hold", bus.dout, 8'hA5);
        wr_reg(16'hFF00, 8'hFF);
        rd_reg(16'hFF0F);
        chk("t5_if_empty", bus.dout, 8'hE0);

        // read and write together return old value
        bus.rd = 1'b1;
        wr_reg(16'hFFFF, 8'h3C);
        bus.rd = 1'b0;
        chk("rw_old", bus.dout, 8'hA5);
        rd_reg(16'hFFFF);
        chk("rw_new", bus.dout, 8'h3C);

        // 6: request latency
        wr_reg(16'hFFFF, 8'h01);
        src_req = 5'h01;
        lat = 0;
        while (irq[0] !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        src_req = 5'h00;
        chk("latency", lat[7:0], LAT[7:0]);

        // reset during an access and mid-synchronizer
        iack = 8'h01;
        tick();
        iack = 8'h00;
        src_req = 5'h01;
        tick();
        bus.adr = 16'hFF0F;
        bus.rd  = 1'b1;
        reset   = 1'b1;
        src_req = 5'h00;
        tick();
        bus.rd  = 1'b0;
        chk("rst_mid_oe", {7'd0, bus.dout_oe}, 8'h00);
        chk("rst_mid_dout", bus.dout, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        wr_reg(16'hFFFF, 8'h1F);
        chk("rst_no_spur", irq, 8'h00);
        rd_reg(16'hFF0F);
        chk("rst_if", bus.dout, 8'hE0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
